// File: rtl/gbe_rxs_snap_ctrl.sv
// 10GbE RX snapshot capture sequencer: arms, triggers, optionally frame-aligns and
// stops the write of RX words into the snapshot BRAM, and reports status.
module gbe_rxs_snap_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 11
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_eof,
  input  logic              ext_trig,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic [31:0]       status
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                trig_seen_q, trig_seen_d;
  logic                in_frame_q, in_frame_d;
  logic                arm_prev_q;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [31:0]         status_q, status_d;

  logic arm_edge, trig_src, frame_align, stop_on_eof;
  logic sof, trig_now, start, stop_now;
  logic [ADDR_W:0] count_inc;

  assign arm_edge    = ctrl[0] & ~arm_prev_q;
  assign trig_src    = ctrl[1];
  assign frame_align = ctrl[2];
  assign stop_on_eof = ctrl[3];

  assign sof       = rx_valid & ~in_frame_q;
  assign trig_now  = trig_src ? ext_trig : 1'b1;
  assign start     = (trig_seen_q | trig_now) & rx_valid & (~frame_align | sof);
  assign stop_now  = stop_on_eof & rx_eof;
  assign count_inc = count_q + ONE;

  always_comb begin
    in_frame_d = in_frame_q;
    if (rx_valid) begin
      in_frame_d = ~rx_eof;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    trig_seen_d = trig_seen_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;

    unique case (state_q)
      IDLE: begin
        if (arm_edge) begin
          state_d     = ARMED;
          count_d     = '0;
          trig_seen_d = 1'b0;
        end
      end
      ARMED: begin
        if (arm_edge) begin
          count_d     = '0;
          trig_seen_d = 1'b0;
        end else begin
          trig_seen_d = trig_seen_q | trig_now;
          if (start) begin
            we_d    = 1'b1;
            addr_d  = '0;
            data_d  = rx_data;
            count_d = ONE;
            state_d = (stop_now || (ONE == DEPTH)) ? DONE : CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (arm_edge) begin
          state_d     = ARMED;
          count_d     = '0;
          trig_seen_d = 1'b0;
        end else if (rx_valid) begin
          we_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          data_d  = rx_data;
          count_d = count_inc;
          if (stop_now || (count_inc == DEPTH)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (arm_edge) begin
          state_d     = ARMED;
          count_d     = '0;
          trig_seen_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status lags the state/count registers by one cycle.
  always_comb begin
    status_d            = '0;
    status_d[31]        = (state_q == DONE);
    status_d[30]        = (state_q == ARMED);
    status_d[29]        = (state_q == CAPTURE);
    status_d[ADDR_W:0]  = count_q;
  end

  // arm_prev resets high so an arm bit held through reset needs a 0->1 toggle.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      trig_seen_q <= 1'b0;
      in_frame_q  <= 1'b0;
      arm_prev_q  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      trig_seen_q <= trig_seen_d;
      in_frame_q  <= in_frame_d;
      arm_prev_q  <= ctrl[0];
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      status_q    <= status_d;
    end
  end

  assign bram_we   = we_q;
  assign bram_addr = addr_q;
  assign bram_data = data_q;
  assign status    = status_q;

endmodule

// File: tb/tb_gbe_rxs_snap_ctrl.sv
// Directed testbench for gbe_rxs_snap_ctrl with a 16-word capture depth.
module tb_gbe_rxs_snap_ctrl;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;

  logic              user_clk = 1'b0;
  logic              user_rst;
  logic [31:0]       ctrl;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_eof;
  logic              ext_trig;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic [31:0]       status;

  int nVec = 0;
  int nErr = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [DATA_W-1:0] wd[$];

  gbe_rxs_snap_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .ctrl     (ctrl),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_eof   (rx_eof),
    .ext_trig (ext_trig),
    .bram_we  (bram_we),
    .bram_addr(bram_addr),
    .bram_data(bram_data),
    .status   (status)
  );

  always #5 user_clk = ~user_clk;

  // Log every BRAM write, sampled mid-cycle.
  always @(negedge user_clk) begin
    if (bram_we === 1'b1) begin
      wa.push_back(bram_addr);
      wd.push_back(bram_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge user_clk);
      #1;
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic test_reset();
    user_rst = 1'b1; ctrl = 32'h0; rx_data = '0; rx_valid = 1'b0; rx_eof = 1'b0; ext_trig = 1'b0;
    tick(3);
    user_rst = 1'b0;
    tick(1);
    nVec++;
    if (bram_we !== 1'b0) begin nErr++; $display("[TB] FAIL reset_we: got %0h expected 0", bram_we); end
    nVec++;
    if (bram_addr !== 4'h0) begin nErr++; $display("[TB] FAIL reset_addr: got %0h expected 0", bram_addr); end
    nVec++;
    if (bram_data !== 64'h0) begin nErr++; $display("[TB] FAIL reset_data: got %0h expected 0", bram_data); end
    nVec++;
    if (status !== 32'h0) begin nErr++; $display("[TB] FAIL reset_status: got %0h expected 0", status); end
  endtask

  task automatic test_immediate();
    clear_log();
    ctrl = 32'h1;
    tick(1);
    for (int i = 0; i < 20; i++) begin
      rx_valid = 1'b1; rx_data = 64'(i);
      tick(1);
    end
    rx_valid = 1'b0;
    tick(2);
    nVec++;
    if (wa.size() != 16) begin nErr++; $display("[TB] FAIL imm_count: got %0d writes expected 16", wa.size()); end
    for (int i = 0; i < 16; i++) begin
      nVec++;
      if (i >= wa.size() || wa[i] !== 4'(i) || wd[i] !== 64'(i)) begin
        nErr++;
        $display("[TB] FAIL imm_write%0d: got addr %0h data %0h expected addr %0h data %0h", i, wa[i], wd[i], i, i);
      end
    end
    nVec++;
    if (status !== 32'h8000_0010) begin nErr++; $display("[TB] FAIL imm_status: got %0h expected 80000010", status); end
    nVec++;
    if (bram_addr !== 4'hF) begin nErr++; $display("[TB] FAIL imm_addr_hold: got %0h expected f", bram_addr); end
  endtask

  task automatic test_ext_trig();
    ctrl = 32'h2;
    tick(1);
    clear_log();
    ctrl = 32'h3;
    tick(1);
    for (int c = 0; c < 20; c++) begin
      rx_valid = 1'b1; rx_data = 64'(100 + c); ext_trig = (c == 10);
      tick(1);
    end
    rx_valid = 1'b0; ext_trig = 1'b0;
    tick(2);
    nVec++;
    if (wa.size() != 10) begin nErr++; $display("[TB] FAIL trig_count: got %0d writes expected 10", wa.size()); end
    nVec++;
    if (wa.size() < 1 || wa[0] !== 4'h0 || wd[0] !== 64'd110) begin
      nErr++; $display("[TB] FAIL trig_first: got addr %0h data %0d expected addr 0 data 110", wa[0], wd[0]);
    end
    nVec++;
    if (wa.size() < 10 || wd[9] !== 64'd119) begin nErr++; $display("[TB] FAIL trig_last: got %0d expected 119", wd[9]); end
    nVec++;
    if (status !== 32'h2000_000A) begin nErr++; $display("[TB] FAIL trig_status: got %0h expected 2000000a", status); end
    // Trigger pulse with no valid data must still be remembered.
    ctrl = 32'h2;
    tick(1);
    ctrl = 32'h3;
    tick(1);
    clear_log();
    ext_trig = 1'b1;
    tick(1);
    ext_trig = 1'b0;
    tick(2);
    nVec++;
    if (status !== 32'h4000_0000) begin nErr++; $display("[TB] FAIL trig_armed: got %0h expected 40000000", status); end
    rx_valid = 1'b1; rx_data = 64'd200;
    tick(1);
    rx_valid = 1'b0;
    tick(1);
    nVec++;
    if (wa.size() != 1 || wa[0] !== 4'h0 || wd[0] !== 64'd200) begin
      nErr++; $display("[TB] FAIL trig_latched: got %0d writes data %0d expected 1 write data 200", wa.size(), wd[0]);
    end
  endtask

  task automatic test_frame_align();
    ctrl = 32'h4;
    tick(1);
    for (int f = 0; f < 6; f++) begin
      for (int w = 0; w < 8; w++) begin
        rx_valid = 1'b1; rx_data = 64'(f * 16 + w); rx_eof = (w == 7);
        ctrl = (f > 3 || (f == 3 && w >= 3)) ? 32'h5 : 32'h4;
        tick(1);
        if (f == 3 && w == 3) clear_log();
      end
    end
    rx_valid = 1'b0; rx_eof = 1'b0;
    tick(2);
    nVec++;
    if (wa.size() != 16) begin nErr++; $display("[TB] FAIL align_count: got %0d writes expected 16", wa.size()); end
    nVec++;
    if (wa.size() < 1 || wa[0] !== 4'h0 || wd[0] !== 64'd64) begin
      nErr++; $display("[TB] FAIL align_first: got addr %0h data %0d expected addr 0 data 64", wa[0], wd[0]);
    end
    nVec++;
    if (wa.size() < 16 || wa[15] !== 4'hF || wd[15] !== 64'd87) begin
      nErr++; $display("[TB] FAIL align_last: got addr %0h data %0d expected addr f data 87", wa[15], wd[15]);
    end
    nVec++;
    if (status !== 32'h8000_0010) begin nErr++; $display("[TB] FAIL align_status: got %0h expected 80000010", status); end
  endtask

  task automatic test_stop_on_eof();
    ctrl = 32'h8;
    tick(1);
    clear_log();
    ctrl = 32'h9;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1'b1; rx_data = 64'(300 + i); rx_eof = (i == 4 || i == 9);
      tick(1);
    end
    rx_valid = 1'b0; rx_eof = 1'b0;
    tick(2);
    nVec++;
    if (wa.size() != 5) begin nErr++; $display("[TB] FAIL eof_count: got %0d writes expected 5", wa.size()); end
    nVec++;
    if (wa.size() < 5 || wd[0] !== 64'd300 || wa[4] !== 4'h4 || wd[4] !== 64'd304) begin
      nErr++; $display("[TB] FAIL eof_words: got first %0d last addr %0h data %0d expected 300 / 4 / 304", wd[0], wa[4], wd[4]);
    end
    nVec++;
    if (status !== 32'h8000_0005) begin nErr++; $display("[TB] FAIL eof_status: got %0h expected 80000005", status); end
  endtask

  task automatic test_back_to_back();
    ctrl = 32'h0;
    tick(1);
    ctrl = 32'h1;
    tick(1);
    clear_log();
    for (int i = 0; i < 7; i++) begin
      rx_valid = 1'b1; rx_data = 64'(500 + i); ctrl = (i == 6) ? 32'h0 : 32'h1;
      tick(1);
    end
    rx_data = 64'd507; ctrl = 32'h1;
    tick(1);
    nVec++;
    if (bram_we !== 1'b0) begin nErr++; $display("[TB] FAIL rearm_we: got %0h expected 0", bram_we); end
    rx_valid = 1'b0;
    tick(2);
    nVec++;
    if (wa.size() != 7) begin nErr++; $display("[TB] FAIL rearm_count: got %0d writes expected 7", wa.size()); end
    nVec++;
    if (status !== 32'h4000_0000) begin nErr++; $display("[TB] FAIL rearm_status: got %0h expected 40000000", status); end
    rx_valid = 1'b1; rx_data = 64'd600;
    tick(1);
    rx_valid = 1'b0;
    tick(1);
    nVec++;
    if (wa.size() != 8 || wa[7] !== 4'h0 || wd[7] !== 64'd600) begin
      nErr++; $display("[TB] FAIL rearm_first: got %0d writes addr %0h data %0d expected 8 / 0 / 600", wa.size(), wa[7], wd[7]);
    end
  endtask

  task automatic test_mid_reset();
    ctrl = 32'h0;
    tick(1);
    ctrl = 32'h1;
    tick(1);
    clear_log();
    for (int i = 0; i < 9; i++) begin
      rx_valid = 1'b1; rx_data = 64'(700 + i);
      tick(1);
    end
    user_rst = 1'b1; rx_data = 64'd709;
    tick(1);
    nVec++;
    if (status !== 32'h0) begin nErr++; $display("[TB] FAIL rst_status: got %0h expected 0", status); end
    nVec++;
    if (bram_we !== 1'b0 || bram_addr !== 4'h0 || bram_data !== 64'h0) begin
      nErr++; $display("[TB] FAIL rst_port: got we %0h addr %0h data %0h expected 0 0 0", bram_we, bram_addr, bram_data);
    end
    user_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_data = 64'(710 + i);
      tick(1);
    end
    nVec++;
    if (wa.size() != 9) begin nErr++; $display("[TB] FAIL rst_no_arm_writes: got %0d writes expected 9", wa.size()); end
    nVec++;
    if (status !== 32'h0) begin nErr++; $display("[TB] FAIL rst_no_arm_status: got %0h expected 0", status); end
    ctrl = 32'h0; rx_data = 64'd719;
    tick(1);
    ctrl = 32'h1; rx_data = 64'd720;
    tick(1);
    rx_data = 64'd721;
    tick(1);
    rx_valid = 1'b0;
    tick(1);
    nVec++;
    if (wa.size() != 10 || wa[9] !== 4'h0 || wd[9] !== 64'd721) begin
      nErr++; $display("[TB] FAIL rst_rearm: got %0d writes addr %0h data %0d expected 10 / 0 / 721", wa.size(), wa[9], wd[9]);
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_ext_trig();
    test_frame_align();
    test_stop_on_eof();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
